// File: rtl/i2s_tx_sched_pkg.sv
// i2s_pkg: shared types and defaults for the I2S transmit scheduler.
//   DEF_DEPTH / DEF_DW : default FIFO depth (stereo pairs) and sample width
//   pair_t             : one stereo pair {l, r} at the default sample width
//   stage_t            : pair-assembly FSM states
//   run_t              : top-level enable FSM states
package i2s_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_DW    = 32;

    typedef struct packed {
        logic [DEF_DW-1:0] l;
        logic [DEF_DW-1:0] r;
    } pair_t;

    typedef enum logic [0:0] {
        STAGE_EMPTY = 1'b0,
        HAVE_L      = 1'b1
    } stage_t;

    typedef enum logic [0:0] {
        DISABLED = 1'b0,
        RUN      = 1'b1
    } run_t;

endpackage

// File: rtl/i2s_tx_sched_if.sv
// i2s_tx_sched_if: sample-write and frame-handshake bundle of i2s_tx_sched.
//   i_wr_l / i_wr_r : single-cycle software write strobes for TXL / TXR
//   i_wdata         : write data accompanying the strobes
//   i_frame_ready   : serializer takes the head pair at a WS frame boundary
//   o_frame_valid   : head pair available
//   o_frame_l/_r    : head pair (zero while o_frame_valid is low)
// Modports: master = software/serializer side, slave = scheduler side.
interface i2s_tx_sched_if
    import i2s_pkg::*;
#(
    parameter int DW = DEF_DW
) ();

    logic          i_wr_l;
    logic          i_wr_r;
    logic [DW-1:0] i_wdata;
    logic          i_frame_ready;
    logic          o_frame_valid;
    logic [DW-1:0] o_frame_l;
    logic [DW-1:0] o_frame_r;

    modport master (
        output i_wr_l, i_wr_r, i_wdata, i_frame_ready,
        input  o_frame_valid, o_frame_l, o_frame_r
    );

    modport slave (
        input  i_wr_l, i_wr_r, i_wdata, i_frame_ready,
        output o_frame_valid, o_frame_l, o_frame_r
    );

endinterface

// File: rtl/i2s_tx_sched_pair_fifo.sv
// i2s_pair_fifo: synchronous first-word-fall-through FIFO of packed pairs.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_flush        : empties the FIFO at the next edge (overrides push/pop)
//   i_push, i_din  : write request and data; accepted if not full or popping
//   i_pop          : read request; ignored when empty
//   o_dout         : head entry, valid one cycle after its push edge
//   o_level        : occupancy 0..DEPTH; o_full / o_empty derived from it
module i2s_pair_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = 2 * DEF_DW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign o_full  = (o_level == LW'(DEPTH));
    assign o_empty = (o_level == '0);
    assign pop_ok  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_dout  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            o_level <= o_level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && push_ok) mem[wr_ptr] <= i_din;
    end

endmodule

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: I2S transmit scheduler. Assembles TXL/TXR software writes
// into stereo pairs, queues them and hands them to the serializer.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_en            : enable (CR bit 0); a falling edge flushes queue and staging
//   bus (slave)     : write strobes/data and frame handshake, see i2s_tx_sched_if
//   o_full/o_empty  : FIFO status; o_level : occupancy 0..DEPTH
//   o_underrun/o_overrun/o_seq_err : sticky flags, cleared by i_flag_clr
//   o_irq           : registered low-watermark/underrun interrupt, present only
//                     when I2S_TX_SCHED_IRQ_EN is defined
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DW     = DEF_DW,
    parameter int LOW_WM = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_flag_clr,
    i2s_tx_sched_if.slave          bus,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_underrun,
    output logic                   o_overrun,
    output logic                   o_seq_err
`ifdef I2S_TX_SCHED_IRQ_EN
    ,
    output logic                   o_irq
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LOW_WM < 0) begin : g_bad_param
        $error("i2s_tx_sched: DEPTH must be a power of 2 >= 2 and LOW_WM >= 0");
    end

    stage_t          stage;
    logic [DW-1:0]   stage_l;
    run_t            run_state;

    logic            both;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            flush;
    logic            underrun_set;
    logic            overrun_set;
    logic            seq_set;
    logic [2*DW-1:0] push_data;
    logic [2*DW-1:0] head;

    always_comb begin
        both         = bus.i_wr_l && bus.i_wr_r;
        push_req     = both || (bus.i_wr_r && stage == HAVE_L);
        push_data    = both ? {bus.i_wdata, bus.i_wdata} : {stage_l, bus.i_wdata};
        seq_set      = bus.i_wr_r && !bus.i_wr_l && stage == STAGE_EMPTY;
        flush        = (run_state == RUN) && !i_en;
        pop          = bus.o_frame_valid && bus.i_frame_ready;
        underrun_set = i_en && bus.i_frame_ready && o_empty;
        overrun_set  = push_req && o_full && !pop;
        // A pair assembled in the flush cycle is discarded with the rest.
        push         = push_req && !flush;
    end

    assign bus.o_frame_valid = i_en && !o_empty;
    assign bus.o_frame_l     = bus.o_frame_valid ? head[2*DW-1:DW] : '0;
    assign bus.o_frame_r     = bus.o_frame_valid ? head[DW-1:0]    : '0;

    i2s_pair_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (flush),
        .i_push  (push),
        .i_din   (push_data),
        .i_pop   (pop),
        .o_dout  (head),
        .o_level (o_level),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run_state <= DISABLED;
        end else begin
            run_state <= i_en ? RUN : DISABLED;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            stage   <= STAGE_EMPTY;
            stage_l <= '0;
        end else if (both) begin
            stage   <= STAGE_EMPTY;
        end else if (bus.i_wr_l) begin
            stage   <= HAVE_L;
            stage_l <= bus.i_wdata;
        end else if (bus.i_wr_r) begin
            stage   <= STAGE_EMPTY;
        end
    end

    // Sticky flags: a same-cycle set beats i_flag_clr.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_underrun <= 1'b0;
            o_overrun  <= 1'b0;
            o_seq_err  <= 1'b0;
        end else begin
            o_underrun <= underrun_set || (o_underrun && !i_flag_clr);
            o_overrun  <= overrun_set  || (o_overrun  && !i_flag_clr);
            o_seq_err  <= seq_set      || (o_seq_err  && !i_flag_clr);
        end
    end

`ifdef I2S_TX_SCHED_IRQ_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= i_en && ((int'(o_level) <= LOW_WM) || o_underrun);
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference model of the scheduler.
module tb_i2s_tx_sched;
    import i2s_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DW     = 32;
    localparam int LOW_WM = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flag_clr;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       underrun;
    logic       overrun;
    logic       seq_err;
`ifdef I2S_TX_SCHED_IRQ_EN
    logic       irq;
`endif

    i2s_tx_sched_if #(.DW(DW)) bus ();

    i2s_tx_sched #(
        .DEPTH  (DEPTH),
        .DW     (DW),
        .LOW_WM (LOW_WM)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_flag_clr (flag_clr),
        .bus        (bus),
        .o_full     (full),
        .o_empty    (empty),
        .o_level    (level),
        .o_underrun (underrun),
        .o_overrun  (overrun),
        .o_seq_err  (seq_err)
`ifdef I2S_TX_SCHED_IRQ_EN
        ,
        .o_irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    pair_t       q[$];
    bit          staged;
    logic [31:0] stl;
    bit          running;
    bit          m_under;
    bit          m_over;
    bit          m_seq;
    bit          m_irq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit wl, input bit wr, input logic [31:0] d, input bit rdy);
        bus.i_wr_l        = wl;
        bus.i_wr_r        = wr;
        bus.i_wdata       = d;
        bus.i_frame_ready = rdy;
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // clock the DUT, then compare every output.
    task automatic cycle();
        pair_t p;
        bit    push, pop, flush, us, os, ss, irq_n;
        int    n;
        logic  exp_valid;
        n = q.size();
        p = '0;
        if (!rst_n) begin
            q.delete();
            staged  = 0;
            stl     = '0;
            running = 0;
            m_under = 0;
            m_over  = 0;
            m_seq   = 0;
            m_irq   = 0;
        end else begin
            pop   = en && n > 0 && bus.i_frame_ready;
            us    = en && bus.i_frame_ready && n == 0;
            flush = running && !en;
            push  = 0;
            if (bus.i_wr_l && bus.i_wr_r) begin
                push = 1; p.l = bus.i_wdata; p.r = bus.i_wdata;
            end else if (bus.i_wr_r && staged) begin
                push = 1; p.l = stl; p.r = bus.i_wdata;
            end
            ss    = bus.i_wr_r && !bus.i_wr_l && !staged;
            os    = push && n == DEPTH && !pop;
            irq_n = en && (n <= LOW_WM || m_under);
            m_under = us || (m_under && !flag_clr);
            m_over  = os || (m_over  && !flag_clr);
            m_seq   = ss || (m_seq   && !flag_clr);
            m_irq   = irq_n;
            if (flush) begin
                q.delete();
                staged = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (push && q.size() < DEPTH) q.push_back(p);
                if (bus.i_wr_l && bus.i_wr_r) staged = 0;
                else if (bus.i_wr_l) begin staged = 1; stl = bus.i_wdata; end
                else if (bus.i_wr_r) staged = 0;
            end
            running = en;
        end
        @(posedge clk);
        #1;
        exp_valid = en && q.size() > 0;
        chk("level", 64'(level), 64'(q.size()));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("frame_valid", 64'(bus.o_frame_valid), 64'(exp_valid));
        chk("frame_l", 64'(bus.o_frame_l), exp_valid ? 64'(q[0].l) : 64'd0);
        chk("frame_r", 64'(bus.o_frame_r), exp_valid ? 64'(q[0].r) : 64'd0);
        chk("underrun", 64'(underrun), 64'(m_under));
        chk("overrun", 64'(overrun), 64'(m_over));
        chk("seq_err", 64'(seq_err), 64'(m_seq));
`ifdef I2S_TX_SCHED_IRQ_EN
        chk("irq", 64'(irq), 64'(m_irq));
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        flag_clr = 1'b0;
        drive(0, 0, '0, 0);
        cycle();
        cycle();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(bus.o_frame_valid), 64'd0);
        rst_n = 1'b1;

        // Basic L then R pair
        en = 1'b1;
        drive(1, 0, 32'hA5A5_0001, 0); cycle();
        drive(0, 1, 32'h5A5A_0002, 0); cycle();
        drive(0, 0, '0, 0);
        chk("pair_valid", 64'(bus.o_frame_valid), 64'd1);
        chk("pair_l", 64'(bus.o_frame_l), 64'hA5A5_0001);
        chk("pair_r", 64'(bus.o_frame_r), 64'h5A5A_0002);
        chk("pair_level", 64'(level), 64'd1);

        // R without L
        en = 1'b0; cycle();
        chk("flush_level", 64'(level), 64'd0);
        drive(0, 1, 32'h1234_5678, 0); cycle();
        drive(0, 0, '0, 0);
        chk("seq_set", 64'(seq_err), 64'd1);
        chk("seq_level", 64'(level), 64'd0);
        flag_clr = 1'b1; cycle(); flag_clr = 1'b0;
        chk("seq_clr", 64'(seq_err), 64'd0);

        // Five pairs into a 4-deep FIFO while disabled (pre-fill)
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 32'(100 + k), 0); cycle();
            drive(0, 1, 32'(200 + k), 0); cycle();
        end
        drive(0, 0, '0, 0);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_flag", 64'(overrun), 64'd1);
        chk("ovf_level", 64'(level), 64'd4);
        en = 1'b1; cycle();
        chk("ovf_head_l", 64'(bus.o_frame_l), 64'd101);
        chk("ovf_head_r", 64'(bus.o_frame_r), 64'd201);

        // Simultaneous push and pop while full
        flag_clr = 1'b1; cycle(); flag_clr = 1'b0;
        drive(1, 0, 32'h300, 0); cycle();
        drive(0, 1, 32'h400, 1); cycle();
        chk("pp_level", 64'(level), 64'd4);
        chk("pp_overrun", 64'(overrun), 64'd0);
        drive(0, 0, '0, 1);
        for (int k = 0; k < 3; k++) cycle();
        chk("pp_new_head_l", 64'(bus.o_frame_l), 64'h300);
        chk("pp_new_head_r", 64'(bus.o_frame_r), 64'h400);
        cycle();
        chk("drained", 64'(empty), 64'd1);

        // Underrun on empty FIFO
        chk("pre_underrun", 64'(underrun), 64'd0);
        cycle();
        drive(0, 0, '0, 0);
        chk("underrun", 64'(underrun), 64'd1);
        cycle();
`ifdef I2S_TX_SCHED_IRQ_EN
        chk("irq_after_underrun", 64'(irq), 64'd1);
`endif

        // Disable flush with two pairs queued, then reset mid-stream
        flag_clr = 1'b1; cycle(); flag_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 32'(16 + k), 0); cycle();
            drive(0, 1, 32'(32 + k), 0); cycle();
        end
        drive(0, 0, '0, 0);
        chk("two_level", 64'(level), 64'd2);
        en = 1'b0; cycle();
        chk("dis_level", 64'(level), 64'd0);
        chk("dis_valid", 64'(bus.o_frame_valid), 64'd0);
        en = 1'b1;
        drive(1, 0, 32'hDEAD_0001, 0); cycle();
        drive(0, 1, 32'hBEEF_0002, 0); cycle();
        drive(1, 0, 32'hCAFE_0003, 0); cycle();
        drive(0, 0, '0, 1); cycle();
        drive(0, 0, '0, 1); cycle();
        rst_n = 1'b0; drive(0, 0, '0, 0); cycle();
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(bus.o_frame_valid), 64'd0);
        chk("mid_rst_l", 64'(bus.o_frame_l), 64'd0);
        chk("mid_rst_under", 64'(underrun), 64'd0);
        rst_n = 1'b1;
        drive(0, 1, 32'h1, 0); cycle();
        drive(0, 0, '0, 0);
        chk("staging_cleared", 64'(seq_err), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            en       = ($urandom_range(0, 19) != 0);
            flag_clr = ($urandom_range(0, 15) == 0);
            drive(1'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_sched.md
I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 Parameter DEPTH, default 4, number of stereo-pair FIFO entries (power of 2, >=2).
REQ-002 Parameter DW, default 32, sample width in bits.
REQ-003 Parameter LOW_WM, default 1, low-watermark level for the interrupt.
REQ-004 i_clk  in  1  sole clock.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_en  in  1  enable, from CR bit 0.
REQ-007 i_wr_l / i_wr_r  in  1 each  single-cycle pulse on a software write of TXL / TXR.
REQ-008 i_wdata  in  DW  write data accompanying i_wr_l/i_wr_r.
REQ-009 o_frame_valid  out  1  head pair available to the serializer.
REQ-010 o_frame_l / o_frame_r  out  DW each  head pair, first-word-fall-through.
REQ-011 i_frame_ready  in  1  serializer consumes a pair at the WS frame boundary.
REQ-012 o_full / o_empty  out  1 each  FIFO status.
REQ-013 o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 o_underrun / o_overrun / o_seq_err  out  1 each  sticky flags.
REQ-015 i_flag_clr  in  1  clears all sticky flags.

Function
REQ-016 The pair-assembly FSM SHALL have two states: STAGE_EMPTY and HAVE_L.
- STAGE_EMPTY + i_wr_l: latch i_wdata as the left sample and go to HAVE_L.
- HAVE_L + i_wr_l: overwrite the staged left sample and stay in HAVE_L.
- HAVE_L + i_wr_r: push {staged L, i_wdata} and go to STAGE_EMPTY.
REQ-017 STAGE_EMPTY + i_wr_r alone: no push; set o_seq_err.
REQ-018 i_wr_l and i_wr_r in the same cycle: push {i_wdata, i_wdata}; the FSM goes to STAGE_EMPTY.
REQ-019 Push while full with no same-cycle pop: drop the pair; set o_overrun.
- Push and pop in the same cycle while full: both are accepted and o_level is unchanged.
REQ-020 Pop occurs when o_frame_valid && i_frame_ready.
- Pushed data SHALL appear at the head one cycle after the push edge.
REQ-021 o_frame_valid = i_en && !o_empty.
- When o_frame_valid is low, o_frame_l/o_frame_r SHALL be zero.
REQ-022 i_en && i_frame_ready && o_empty: set o_underrun; nothing is popped.
REQ-023 The top FSM SHALL have two states: DISABLED and RUN.
- A falling i_en flushes the FIFO and staging at the next edge and returns to DISABLED.
- In DISABLED, writes are still assembled and pushed (pre-fill).
REQ-024 Sticky flags hold until i_flag_clr.
- If a set and i_flag_clr occur in the same cycle, the set wins.
REQ-025 Read/write pointers wrap modulo DEPTH.
- o_level SHALL count 0..DEPTH with no wrap.
- o_full = (o_level == DEPTH); o_empty = (o_level == 0).

Reset
REQ-026 When i_rst_n is sampled low, the block SHALL reset at the next edge:
- FIFO empty, o_level=0, o_empty=1, o_full=0;
- o_frame_valid=0, o_frame_l/o_frame_r=0;
- all sticky flags 0;
- FSMs in STAGE_EMPTY and DISABLED.
REQ-027 Reset mid-transfer SHALL discard any staged or queued pairs with no partial output.

Configuration
REQ-028 With I2S_TX_SCHED_IRQ_EN defined, an output port o_irq (1 bit) SHALL be present.
- o_irq is registered and equals i_en && (o_level <= LOW_WM || o_underrun).
- o_irq resets to 0.
REQ-029 Without I2S_TX_SCHED_IRQ_EN, the o_irq port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package i2s_pkg SHALL hold:
- the pair struct typedef {l, r};
- the FSM state enums;
- the default DEPTH/DW constants.
REQ-031 Storage SHALL be a sub-module i2s_pair_fifo: synchronous, first-word-fall-through, with push/pop/level ports.

Verification
REQ-032 Write L=0xA5A5_0001, then R=0x5A5A_0002 with i_en=1:
- one cycle later o_frame_valid=1, o_frame_l=0xA5A5_0001, o_frame_r=0x5A5A_0002, o_level=1.
REQ-033 Write R first with no prior L:
- o_seq_err=1, o_level=0;
- after i_flag_clr, o_seq_err=0.
REQ-034 Push 5 pairs with DEPTH=4 and i_frame_ready=0:
- o_full=1, o_overrun=1, o_level=4;
- the head is still pair 1.
REQ-035 Full FIFO, then a push and a pop in the same cycle:
- o_level stays 4, o_overrun stays 0;
- the new pair is delivered as the 4th subsequent pop.
REQ-036 Empty FIFO with i_en=1 and i_frame_ready=1 for one cycle:
- o_underrun=1;
- o_irq=1 one cycle later (macro defined).
REQ-037 Two pairs queued, then i_en dropped:
- next cycle o_level=0, o_frame_valid=0;
- i_rst_n=0 mid-stream gives all outputs 0 at the next edge.
